// File: rtl/telemetry_deserialize.sv
// Serial telemetry receiver: hunts for the sync word, shifts in one payload plus
// its CRC-8, then reports a good packet or an error as single-cycle pulses.
module telemetry_deserialize #(
  parameter int          PACKET_W  = 88,
  parameter logic [7:0]  SYNC_WORD = 8'hA5,
  parameter int          TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                reset_clk,
  input  logic                bit_in,
  input  logic                bit_valid,
  output logic [PACKET_W-1:0] packet,
  output logic                packet_valid,
  output logic                crc_error,
  output logic                timeout_error,
  output logic                in_frame,
  output logic [15:0]         good_count,
  output logic [15:0]         err_count,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_CRC     = 2'd2;

  localparam int CNT_W = $clog2(PACKET_W);
  localparam int GAP_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_PAYLOAD = CNT_W'(PACKET_W - 1);
  localparam logic [CNT_W-1:0] LAST_CRC     = CNT_W'(7);
  localparam logic [GAP_W-1:0] GAP_LIMIT    = GAP_W'(TIMEOUT);

  logic [1:0]          state_q,   state_d;
  logic [7:0]          window_q,  window_d;
  logic [PACKET_W-1:0] payload_q, payload_d;
  logic [7:0]          crc_q,     crc_d;
  logic [7:0]          rx_crc_q,  rx_crc_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]    gap_q,     gap_d;
  logic                check_q,   check_d;
  logic [PACKET_W-1:0] packet_q,  packet_d;
  logic                pv_q,      pv_d;
  logic                crc_err_q, crc_err_d;
  logic                to_q,      to_d;
  logic [15:0]         good_q,    good_d;
  logic [15:0]         err_q,     err_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Serial CRC-8, polynomial 0x07, MSB first.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  always_comb begin
    state_d   = state_q;
    window_d  = window_q;
    payload_d = payload_q;
    crc_d     = crc_q;
    rx_crc_d  = rx_crc_q;
    bit_cnt_d = bit_cnt_q;
    gap_d     = gap_q;
    check_d   = 1'b0;
    packet_d  = packet_q;
    pv_d      = 1'b0;
    crc_err_d = 1'b0;
    to_d      = 1'b0;
    good_d    = good_q;
    err_d     = err_q;

    // The comparison runs one cycle after the last CRC bit, while the FSM is
    // already back in HUNT, so a back-to-back sync word is never missed.
    if (check_q) begin
      if (rx_crc_q == crc_q) begin
        packet_d = payload_q;
        pv_d     = 1'b1;
        good_d   = sat_inc(good_q);
      end else begin
        crc_err_d = 1'b1;
        err_d     = sat_inc(err_q);
      end
    end

    case (state_q)
      ST_HUNT: begin
        if (bit_valid) begin
          window_d = {window_q[6:0], bit_in};
          if (window_d == SYNC_WORD) begin
            state_d   = ST_PAYLOAD;
            bit_cnt_d = '0;
            crc_d     = '0;
            gap_d     = '0;
          end
        end
      end
      ST_PAYLOAD, ST_CRC: begin
        if (bit_valid) begin
          gap_d = '0;
          if (state_q == ST_PAYLOAD) begin
            payload_d = {payload_q[PACKET_W-2:0], bit_in};
            crc_d     = crc_step(crc_q, bit_in);
            if (bit_cnt_q == LAST_PAYLOAD) begin
              state_d   = ST_CRC;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else begin
            rx_crc_d = {rx_crc_q[6:0], bit_in};
            if (bit_cnt_q == LAST_CRC) begin
              state_d  = ST_HUNT;
              window_d = '0;
              check_d  = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
          if (gap_d == GAP_LIMIT) begin
            to_d     = 1'b1;
            err_d    = sat_inc(err_q);
            state_d  = ST_HUNT;
            window_d = '0;
            gap_d    = '0;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_clk) begin
      state_q   <= ST_HUNT;
      window_q  <= '0;
      payload_q <= '0;
      crc_q     <= '0;
      rx_crc_q  <= '0;
      bit_cnt_q <= '0;
      gap_q     <= '0;
      check_q   <= 1'b0;
      packet_q  <= '0;
      pv_q      <= 1'b0;
      crc_err_q <= 1'b0;
      to_q      <= 1'b0;
      good_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      window_q  <= window_d;
      payload_q <= payload_d;
      crc_q     <= crc_d;
      rx_crc_q  <= rx_crc_d;
      bit_cnt_q <= bit_cnt_d;
      gap_q     <= gap_d;
      check_q   <= check_d;
      packet_q  <= packet_d;
      pv_q      <= pv_d;
      crc_err_q <= crc_err_d;
      to_q      <= to_d;
      good_q    <= good_d;
      err_q     <= err_d;
    end
  end

  assign packet        = packet_q;
  assign packet_valid  = pv_q;
  assign crc_error     = crc_err_q;
  assign timeout_error = to_q;
  assign in_frame      = (state_q == ST_PAYLOAD) || (state_q == ST_CRC);
  assign good_count    = good_q;
  assign err_count     = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_telemetry_deserialize.sv
// Bench for telemetry_deserialize: frame-level driver, event-scheduled reference
// model checked every cycle, plus hand-computed spot values.
module tb_telemetry_deserialize;
  localparam int PW = 88;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          reset_clk = 1'b1;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic [PW-1:0] packet;
  logic          packet_valid, crc_error, timeout_error, in_frame;
  logic [15:0]   good_count, err_count;
  logic [1:0]    dbg_state;

  telemetry_deserialize dut (
    .clk(clk), .reset_clk(reset_clk), .bit_in(bit_in), .bit_valid(bit_valid),
    .packet(packet), .packet_valid(packet_valid), .crc_error(crc_error),
    .timeout_error(timeout_error), .in_frame(in_frame),
    .good_count(good_count), .err_count(err_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model state: expected packets and scheduled pulse kinds by edge.
  logic [PW-1:0] exp_q[$];
  int            exp_kind[int];   // 1 = good, 2 = crc error, 3 = timeout
  logic [PW-1:0] mdl_packet = '0;
  logic [15:0]   mdl_good = '0, mdl_err = '0;
  int            edge_n = 0;
  bit            chk_en = 1'b0;
  int            n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // CRC as polynomial long division of payload*x^8 by 0x107.
  function automatic logic [7:0] crc8(input logic [PW-1:0] p);
    logic [PW+7:0] m;
    m = {p, 8'h00};
    for (int i = PW + 7; i >= 8; i--)
      if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
    return m[7:0];
  endfunction

  task automatic step(input logic b, input logic v);
    bit_in = b;
    bit_valid = v;
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic do_reset();
    reset_clk = 1'b1;
    bit_valid = 1'b0;
    @(posedge clk);
    edge_n++;
    mdl_good = '0;
    mdl_err = '0;
    mdl_packet = '0;
    exp_q.delete();
    exp_kind.delete();
    #1;
    reset_clk = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int spacing);
    repeat (spacing) step(1'($urandom_range(0, 1)), 1'b0);
    step(b, 1'b1);
  endtask

  task automatic send_head(input logic [PW-1:0] p, input int nbits, input int spacing);
    for (int i = 7; i >= 0; i--) send_bit(SYNC[i], spacing);
    for (int i = 0; i < nbits; i++) send_bit(p[PW-1-i], spacing);
  endtask

  task automatic send_frame(input logic [PW-1:0] p, input logic [7:0] c, input int spacing);
    send_head(p, PW, spacing);
    for (int i = 7; i >= 0; i--) send_bit(c[i], spacing);
    if (c == crc8(p)) begin
      exp_kind[edge_n + 1] = 1;
      exp_q.push_back(p);
    end else begin
      exp_kind[edge_n + 1] = 2;
    end
  endtask

  // Random valid idle bits that never form the sync word, then 7 zeros so the
  // following sync can only match at its own last bit.
  task automatic send_idle(input int n);
    logic [7:0] hist;
    logic b;
    hist = '0;
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      if ({hist[6:0], b} == SYNC) b = ~b;
      hist = {hist[6:0], b};
      step(b, 1'b1);
    end
    repeat (7) step(1'b0, 1'b1);
  endtask

  // Per-cycle compare against the scheduled model.
  always @(negedge clk) begin
    if (chk_en) begin
      int kind;
      kind = exp_kind.exists(edge_n) ? exp_kind[edge_n] : 0;
      chk("packet_valid", PW'(packet_valid), PW'(kind == 1));
      chk("crc_error", PW'(crc_error), PW'(kind == 2));
      chk("timeout_error", PW'(timeout_error), PW'(kind == 3));
      if (kind == 1) begin
        if (exp_q.size() > 0) mdl_packet = exp_q.pop_front();
        if (mdl_good != 16'hFFFF) mdl_good++;
      end else if (kind == 2 || kind == 3) begin
        if (mdl_err != 16'hFFFF) mdl_err++;
      end
      chk("packet", packet, mdl_packet);
      chk("good_count", PW'(good_count), PW'(mdl_good));
      chk("err_count", PW'(err_count), PW'(mdl_err));
    end
  end

  localparam logic [PW-1:0] P_A5 = 88'hA5A5_00A5_A5A5_1234_5678_A5;
  localparam logic [PW-1:0] P_TO = 88'h0123_4567_89AB_CDEF_FEDC_BA;

  initial begin
    int e;
    do_reset();
    step(1'b0, 1'b0);
    chk_en = 1'b1;
    chk("rst_packet", packet, '0);
    chk("rst_good", PW'(good_count), '0);
    chk("rst_err", PW'(err_count), '0);
    chk("rst_in_frame", PW'(in_frame), '0);
    chk("rst_state", PW'(dbg_state), '0);

    // Zero payload with literal CRC 0x00.
    send_frame('0, 8'h00, 0);
    step(1'b0, 1'b0);
    chk("t1_pv", PW'(packet_valid), PW'(1));
    chk("t1_packet", packet, '0);
    chk("t1_good", PW'(good_count), PW'(1));

    // Payload 1 with literal CRC 0x07, then the same frame with CRC 0x06.
    send_frame(88'h1, 8'h07, 0);
    step(1'b0, 1'b0);
    chk("t2_packet", packet, 88'h1);
    chk("t2_good", PW'(good_count), PW'(2));
    send_frame(88'h1, 8'h06, 0);
    step(1'b0, 1'b0);
    chk("t2_crc_error", PW'(crc_error), PW'(1));
    chk("t2_hold", packet, 88'h1);
    chk("t2_err", PW'(err_count), PW'(1));

    // Random idle, then a payload full of sync bytes at 1-in-4 bit rate.
    send_idle(20);
    send_frame(P_A5, crc8(P_A5), 3);
    repeat (2) step(1'b0, 1'b0);
    chk("t3_packet", packet, P_A5);
    chk("t3_good", PW'(good_count), PW'(3));

    // Stall after payload bit 40.
    send_head(P_TO, 40, 0);
    chk("t4_in_frame_mid", PW'(in_frame), PW'(1));
    exp_kind[edge_n + 64] = 3;
    repeat (64) step(1'b0, 1'b0);
    chk("t4_timeout", PW'(timeout_error), PW'(1));
    chk("t4_in_frame", PW'(in_frame), '0);
    chk("t4_err", PW'(err_count), PW'(2));
    send_frame(P_TO, crc8(P_TO), 0);
    step(1'b0, 1'b0);
    chk("t4_recover", packet, P_TO);

    // Reset mid-payload.
    send_head(P_A5, 30, 0);
    do_reset();
    chk("t5_good", PW'(good_count), '0);
    chk("t5_err", PW'(err_count), '0);
    chk("t5_packet", packet, '0);
    chk("t5_in_frame", PW'(in_frame), '0);
    send_frame(P_TO, crc8(P_TO), 0);
    step(1'b0, 1'b0);
    chk("t5_recover", packet, P_TO);

    // Three back-to-back counter-style packets.
    for (int i = 0; i < 3; i++) begin
      logic [PW-1:0] p;
      p = {24'h544C4D, 32'(i + 1), 32'h1000_0000 + 32'(i)};
      send_frame(p, crc8(p), 0);
    end
    repeat (3) step(1'b0, 1'b0);
    chk("t6_good", PW'(good_count), PW'(4));
    chk("t6_last", packet, {24'h544C4D, 32'd3, 32'h1000_0002});
    chk("t6_err", PW'(err_count), '0);
    e = exp_q.size();
    chk("exp_q_drained", PW'(e), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
